// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: instruction field widths, opcode map
// and the prefetch FSM state encoding used by the fetch unit.
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 8;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDI0 = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD0 = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB0 = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_LDI1 = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_ADD1 = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_SUB1 = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_OUT  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_JC   = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        VALID   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction register and one-entry prefetch buffer that
// feed the control unit, reading program memory over a req/ack handshake.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pc_inc,
    input  logic                pc_load,
    input  logic                ir_load,
    input  logic                halt,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [INSTR_W-1:0]  mem_rdata,
    input  logic                mem_ack,
    output logic [3:0]          opcode,
    output logic [3:0]          operand,
    output logic [ADDR_W-1:0]   pc,
    output logic                buf_valid,
    output logic                fetch_stall
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic               fetch_stall_q, fetch_stall_d;
    logic               mem_req_q, mem_req_d;

    logic               inc_en, load_en, irl_en, ack;
    logic [ADDR_W-1:0]  fill_addr;

    always_comb begin
        inc_en  = pc_inc  & ~halt;
        load_en = pc_load & ~halt;
        irl_en  = ir_load & ~halt & ~fetch_stall_q;
        // An ack is only meaningful against a request this unit actually has open.
        ack     = mem_ack & mem_req_q;

        pc_d = pc_q;
        if (load_en) begin
            pc_d = ADDR_W'(ir_q[OPCODE_W-1:0]);
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        ir_d          = ir_q;
        fetch_stall_d = fetch_stall_q;
        pend_addr_d   = pend_addr_q;
        if (irl_en) begin
            if (state_q == VALID) begin
                ir_d = buf_q;
            end else begin
                fetch_stall_d = 1'b1;
                pend_addr_d   = pc_q;
            end
        end
        if (ack && state_q == FILL && fetch_stall_q) begin
            ir_d          = mem_rdata;
            fetch_stall_d = 1'b0;
        end

        // A pending load must be served before the buffer chases the moving PC.
        fill_addr = fetch_stall_d ? pend_addr_d : pc_d;

        state_d    = state_q;
        req_addr_d = req_addr_q;
        buf_d      = buf_q;
        case (state_q)
            FILL: begin
                if (ack) begin
                    buf_d = mem_rdata;
                    if (fetch_stall_q) begin
                        req_addr_d = pc_d;
                    end else if (!fetch_stall_d && req_addr_q == pc_d) begin
                        state_d = VALID;
                    end else begin
                        req_addr_d = fill_addr;
                    end
                end else if (!mem_req_q) begin
                    req_addr_d = fill_addr;
                end else if (!fetch_stall_d && pc_d != req_addr_q) begin
                    state_d = DISCARD;
                end
            end
            VALID: begin
                if (pc_d != pc_q) begin
                    state_d    = FILL;
                    req_addr_d = pc_d;
                end
            end
            DISCARD: begin
                if (ack || !mem_req_q) begin
                    state_d    = FILL;
                    req_addr_d = fill_addr;
                end
            end
            default: begin
                state_d    = FILL;
                req_addr_d = pc_d;
            end
        endcase

        // An open request is held to completion even under halt; halt only blocks new ones.
        if (mem_req_q && !ack) begin
            mem_req_d = 1'b1;
        end else begin
            mem_req_d = (state_d != VALID) && !halt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            pc_q          <= '0;
            req_addr_q    <= '0;
            pend_addr_q   <= '0;
            ir_q          <= '0;
            buf_q         <= '0;
            fetch_stall_q <= 1'b0;
            mem_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            pend_addr_q   <= pend_addr_d;
            ir_q          <= ir_d;
            buf_q         <= buf_d;
            fetch_stall_q <= fetch_stall_d;
            mem_req_q     <= mem_req_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = req_addr_q;
    assign opcode      = ir_q[INSTR_W-1 -: OPCODE_W];
    assign operand     = ir_q[OPCODE_W-1:0];
    assign pc          = pc_q;
    assign buf_valid   = (state_q == VALID);
    assign fetch_stall = fetch_stall_q;

    ir_load_while_stalled: assert property (@(posedge clk) disable iff (reset)
        !(ir_load && fetch_stall_q));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Owns the program counter, the instruction register and a one-entry prefetch buffer for the 8-bit CPU. It sits directly upstream of the control unit.
- Consumes the control unit's pc_inc, pc_load, ir_load and halt strobes.
- Drives opcode/operand back into the control unit and the datapath.
- Reads program memory through a req/ack handshake that tolerates any number of wait states.

Parameters:
- ADDR_W, 4, program-counter and memory-address width; the jump target is zero-extended operand.
- INSTR_W, 8, instruction width: opcode = instr[7:4], operand = instr[3:0].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pc_inc  in  1  advance PC by 1 (one-cycle strobe).
- pc_load  in  1  load PC from the IR operand.
- ir_load  in  1  capture the instruction at the current PC into IR.
- halt  in  1  level; freezes PC, IR and new fetches.
- mem_req  out  1  memory read request; held until ack.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_rdata  in  INSTR_W  read data; valid when mem_ack=1.
- mem_ack  in  1  one-cycle acknowledge; only legal while mem_req=1.
- opcode  out  4  IR[7:4].
- operand  out  4  IR[3:0] (immediate or jump address).
- pc  out  ADDR_W  current PC.
- buf_valid  out  1  prefetch buffer holds the instruction at pc.
- fetch_stall  out  1  an ir_load is pending on memory.

Behaviour:
- Reset values: pc=0, IR=0 (opcode NOP), buf_valid=0, fetch_stall=0, mem_req=0, mem_addr=0. FSM goes to FILL; mem_req rises the first cycle after reset deasserts.
- Reset mid-transaction aborts it. Any late mem_ack after reset is ignored.
- Prefetch FSM states:
  - FILL: mem_req=1, mem_addr=req_addr. On ack, capture mem_rdata into the buffer.
    - If a load is pending, IR<=mem_rdata, clear fetch_stall, and restart FILL at the current pc.
    - Else, if req_addr==pc, go to VALID.
    - Else (pc moved without a pending load), restart FILL at pc.
  - VALID: mem_req=0, buf_valid=1. On any PC change, go to FILL with req_addr=new pc.
  - DISCARD: PC changed during FILL with no pending load. Keep mem_req high until ack, drop the data, then go to FILL at pc.
- ir_load while buf_valid=1: IR<=buffer in the same edge, with zero added latency. opcode/operand update the cycle after the strobe.
- ir_load while buf_valid=0: set fetch_stall and latch pend_addr=pc. The in-flight request for pend_addr is never discarded. IR loads on its ack, so added latency equals the memory wait states.
- PC update priority: pc_load > pc_inc.
  - pc_load: pc<={0, IR[3:0]}, using the IR value before any same-edge ir_load.
  - pc_inc: pc<=pc+1, wrapping modulo 2^ADDR_W (pc=15 goes to 0 for ADDR_W=4).
- ir_load together with pc_inc in one cycle (the normal fetch): IR takes the instruction at the old pc; pc becomes old+1.
- ir_load together with pc_load in one cycle: IR takes the instruction at the old pc; pc takes the old-IR operand.
- ir_load while fetch_stall=1: protocol error. It is ignored; an assertion flags it in simulation.
- halt=1:
  - Ignore pc_inc, pc_load and ir_load.
  - An outstanding request completes and its data is still captured or discarded by the rules above.
  - No new request is issued.
  - On halt deassertion the FSM resumes from its held state.
- mem_addr and mem_req are registered, so there is no combinational path from the strobes to memory.

Decomposition:
- Shared package cpu_pkg holds:
  - constants OPCODE_W=4, INSTR_W=8;
  - opcode localparams OP_NOP, OP_LDI0, OP_ADD0, OP_SUB0, OP_LDI1, OP_ADD1, OP_SUB1, OP_OUT, OP_JMP, OP_JZ, OP_JC, OP_HLT;
  - the fetch FSM state enum (FILL, VALID, DISCARD).
- No sub-module; PC, IR and prefetch FSM stay in one module.

Test Plan:
- Reset then zero-wait memory with mem[0]=0x15, mem[1]=0x23; assert ir_load+pc_inc at cycle 3.
  -> opcode=1, operand=5, pc=1, fetch_stall never set; the buffer refills with 0x23.
- 3-wait-state memory; ir_load+pc_inc asserted while buf_valid=0 at pc=0.
  -> fetch_stall=1 for 3 cycles; IR=mem[0] on ack; then a fetch request for addr 1.
- IR=0x8C (JMP 12); pc_load while a request for pc+1 is outstanding.
  -> FSM goes to DISCARD, stale data is dropped, pc=12, the next mem_addr is 12, and buf_valid reflects mem[12].
- pc=15 with pc_inc.
  -> pc=0 and mem_addr=0 on the next request.
- halt=1 during FILL; 5 pc_inc pulses; ack arrives.
  -> pc unchanged, the buffer is captured, no second mem_req; after halt drops, normal fetch resumes.
- Assert reset mid-FILL, then ack arrives after reset is released.
  -> all outputs return to reset values, the late ack is ignored, and a fresh request is issued at addr 0.
